// File: rtl/alu_muldiv.sv
// Iterative radix-2 multiply/divide unit for the RV32M operation set.
// Operands are taken as magnitudes, and the signs are applied on the final iteration.
module alu_muldiv #(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_WIDTH-1:0]    SrcA,
    input  logic [DATA_WIDTH-1:0]    SrcB,
    input  logic [OPCODE_LENGTH-1:0] Operation,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_WIDTH-1:0]    ALUResult,
    output logic                     busy
);

    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(W) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);
    localparam logic [W-1:0]  MOST_NEG = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    op_q, op_d;
    logic          a_neg_q, a_neg_d, b_neg_q, b_neg_d;
    logic          fast_q, fast_d;
    logic [W-1:0]  opnd_q, opnd_d;
    logic [W-1:0]  hi_q, hi_d, lo_q, lo_d;
    logic [W-1:0]  res_q, res_d;

    logic [2:0]     in_op;
    logic           a_sgn, b_sgn, a_neg, b_neg;
    logic [W-1:0]   a_mag, b_mag;
    logic           div_zero, div_ovf;
    logic [W:0]     mul_sum, div_shift, div_diff;
    logic [W-1:0]   hi_n, lo_n, quot, rem;
    logic [2*W-1:0] prod, prod_s;
    logic [W-1:0]   final_res;

    // Operand decode at the accept edge
    always_comb begin
        in_op    = Operation[2:0];
        a_sgn    = (in_op == 3'b001) || (in_op == 3'b010) || (in_op == 3'b100) || (in_op == 3'b110);
        b_sgn    = (in_op == 3'b001) || (in_op == 3'b100) || (in_op == 3'b110);
        a_neg    = a_sgn & SrcA[W-1];
        b_neg    = b_sgn & SrcB[W-1];
        a_mag    = a_neg ? -SrcA : SrcA;
        b_mag    = b_neg ? -SrcB : SrcB;
        div_zero = in_op[2] && (SrcB == '0);
        div_ovf  = in_op[2] && !in_op[0] && (SrcA == MOST_NEG) && (SrcB == '1);
    end

    // One iteration: shift-add for multiply, restoring shift-subtract for divide
    always_comb begin
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
        div_shift = {hi_q, lo_q[W-1]};
        div_diff  = div_shift - {1'b0, opnd_q};
        if (op_q[2]) begin
            hi_n = div_diff[W] ? div_shift[W-1:0] : div_diff[W-1:0];
            lo_n = {lo_q[W-2:0], ~div_diff[W]};
        end else begin
            {hi_n, lo_n} = {mul_sum, lo_q[W-1:1]};
        end
        prod   = {hi_n, lo_n};
        prod_s = (a_neg_q ^ b_neg_q) ? -prod : prod;
        quot   = (a_neg_q ^ b_neg_q) ? -lo_n : lo_n;
        rem    = a_neg_q ? -hi_n : hi_n;
        case (op_q)
            3'b000:                 final_res = prod_s[W-1:0];
            3'b001, 3'b010, 3'b011: final_res = prod_s[2*W-1:W];
            3'b100, 3'b101:         final_res = quot;
            default:                final_res = rem;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_neg_d = a_neg_q;
        b_neg_d = b_neg_q;
        fast_d  = fast_q;
        opnd_d  = opnd_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        res_d   = res_q;
        if (flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        state_d = S_BUSY;
                        cnt_d   = '0;
                        op_d    = in_op;
                        a_neg_d = a_neg;
                        b_neg_d = b_neg;
                        hi_d    = '0;
                        opnd_d  = in_op[2] ? b_mag : a_mag;
                        lo_d    = in_op[2] ? a_mag : b_mag;
                        // Fast-path result parks in lo_q and is published after one BUSY edge
                        fast_d  = div_zero || div_ovf;
                        if (div_zero)
                            lo_d = in_op[1] ? SrcA : '1;
                        else if (div_ovf)
                            lo_d = in_op[1] ? '0 : MOST_NEG;
                    end
                end
                S_BUSY: begin
                    if (fast_q) begin
                        state_d = S_DONE;
                        res_d   = lo_q;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                        hi_d  = hi_n;
                        lo_d  = lo_n;
                        if (cnt_q == CNT_LAST) begin
                            state_d = S_DONE;
                            res_d   = final_res;
                        end
                    end
                end
                S_DONE: begin
                    if (out_ready)
                        state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            a_neg_q <= 1'b0;
            b_neg_q <= 1'b0;
            fast_q  <= 1'b0;
            opnd_q  <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_neg_q <= a_neg_d;
            b_neg_q <= b_neg_d;
            fast_q  <= fast_d;
            opnd_q  <= opnd_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            res_q   <= res_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign ALUResult = res_q;

endmodule
